// File: rtl/hash_display_sequencer.sv
// Sequences SHA-256 runs and presents the captured digest one 16-bit word at a time.
// The AUTO_SCAN_EN macro adds tick-driven auto-scan of the displayed word.
module hash_display_sequencer #(
  parameter int DWELL   = 500,
  parameter int TIMEOUT = 4096
) (
  input  logic         sysclk_125mhz,
  input  logic         rst,
  input  logic         go,
  input  logic         step,
  input  logic         tick,
  input  logic         hash_done,
  input  logic [255:0] hash_digest,
  output logic         hash_start,
  output logic [3:0]   word_sel,
  output logic [15:0]  word,
  output logic         busy,
  output logic         valid,
  output logic         err,
  output logic [1:0]   fsm_state
);

  // Handshake: hash_start is a one-cycle request; the core answers with a
  // one-cycle hash_done strobe and hash_digest is sampled only with it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    SHOW  = 2'd3
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_next;
  logic          go_q;
  logic          step_q;
  logic          go_rise;
  logic          step_rise;
  logic [CW-1:0] wait_cnt;
  logic          timeout_hit;
  logic [255:0]  digest;
  logic          advance;

  assign go_rise     = go & ~go_q;
  assign step_rise   = step & ~step_q;
  assign timeout_hit = (wait_cnt == WAIT_LAST);

  always_ff @(posedge sysclk_125mhz or negedge rst) begin
    if (!rst) begin
      go_q   <= 1'b0;
      step_q <= 1'b0;
    end else begin
      go_q   <= go;
      step_q <= step;
    end
  end

  always_ff @(posedge sysclk_125mhz or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (go_rise) state_next = START;
      START: state_next = WAIT;
      WAIT: begin
        if (hash_done)        state_next = SHOW;
        else if (timeout_hit) state_next = IDLE;
      end
      SHOW:  if (go_rise) state_next = START;
      default: state_next = IDLE;
    endcase
  end

  assign hash_start = (state == START);
  assign busy       = (state == START) || (state == WAIT);
  assign fsm_state  = state;

  // Counter idles at zero outside WAIT, so every WAIT entry starts from 0.
  always_ff @(posedge sysclk_125mhz or negedge rst) begin
    if (!rst)                wait_cnt <= '0;
    else if (state != WAIT)  wait_cnt <= '0;
    else                     wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge sysclk_125mhz or negedge rst) begin
    if (!rst) begin
      valid  <= 1'b0;
      err    <= 1'b0;
      digest <= '0;
    end else begin
      if (((state == IDLE) || (state == SHOW)) && go_rise) begin
        valid <= 1'b0;
        err   <= 1'b0;
      end else if (state == WAIT) begin
        if (hash_done) begin
          digest <= hash_digest;
          valid  <= 1'b1;
        end else if (timeout_hit) begin
          valid <= 1'b0;
          err   <= 1'b1;
        end
      end
    end
  end

`ifdef AUTO_SCAN_EN
  localparam int DW = $clog2(DWELL + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  logic [DW-1:0] dwell_cnt;
  logic          dwell_hit;

  assign dwell_hit = tick && (dwell_cnt == DWELL_LAST);

  // A step edge restarts the dwell and absorbs a coincident expiry.
  always_ff @(posedge sysclk_125mhz or negedge rst) begin
    if (!rst)                      dwell_cnt <= '0;
    else if (state != SHOW)        dwell_cnt <= '0;
    else if (step_rise)            dwell_cnt <= '0;
    else if (dwell_hit)            dwell_cnt <= '0;
    else if (tick)                 dwell_cnt <= dwell_cnt + 1'b1;
  end

  assign advance = (state == SHOW) && (step_rise || dwell_hit);
`else
  logic        unused_tick;
  logic [31:0] unused_dwell;
  assign unused_tick  = tick;
  assign unused_dwell = DWELL;
  assign advance      = (state == SHOW) && step_rise;
`endif

  always_ff @(posedge sysclk_125mhz or negedge rst) begin
    if (!rst)                               word_sel <= 4'd0;
    else if ((state == WAIT) && hash_done)  word_sel <= 4'd0;
    else if (advance)                       word_sel <= word_sel + 4'd1;
  end

  assign word = digest[{word_sel, 4'b0000} +: 16];

endmodule

// File: tb/tb_hash_display_sequencer.sv
// Randomized bench for hash_display_sequencer against a behavioural reference model,
// with directed reset, capture, stepping, timeout and reset-in-wait scenarios.
module tb_hash_display_sequencer;

  localparam int TIMEOUT = 16;
  localparam int DWELL   = 2;
  localparam int M_IDLE  = 0;
  localparam int M_START = 1;
  localparam int M_WAIT  = 2;
  localparam int M_SHOW  = 3;

  logic         clk;
  logic         rst;
  logic         go;
  logic         step;
  logic         tick;
  logic         hash_done;
  logic [255:0] hash_digest;
  logic         hash_start;
  logic [3:0]   word_sel;
  logic [15:0]  word;
  logic         busy;
  logic         valid;
  logic         err;
  logic [1:0]   fsm_state;

  hash_display_sequencer #(.DWELL(DWELL), .TIMEOUT(TIMEOUT)) dut (
    .sysclk_125mhz(clk),
    .rst(rst),
    .go(go),
    .step(step),
    .tick(tick),
    .hash_done(hash_done),
    .hash_digest(hash_digest),
    .hash_start(hash_start),
    .word_sel(word_sel),
    .word(word),
    .busy(busy),
    .valid(valid),
    .err(err),
    .fsm_state(fsm_state)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: mode, elapsed wait cycles, the 16 captured words, display index
  int          m_mode;
  int          m_wait_n;
  int          m_dwell;
  logic [15:0] m_words[16];
  int          m_sel;
  bit          m_valid;
  bit          m_err;
  bit          m_go_prev;
  bit          m_step_prev;

  localparam logic [255:0] REF_DIGEST =
    256'hd0e8b8f11c98f369016eb2ed3c541e1f01382f9d5b3104c9ffd06b6175a46271;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_wait_n = 0; m_dwell = 0; m_sel = 0;
    m_valid = 0; m_err = 0; m_go_prev = 0; m_step_prev = 0;
    for (int i = 0; i < 16; i++) m_words[i] = 16'h0;
  endtask

  task automatic check_all();
    check("state", 32'(fsm_state), 32'(m_mode));
    check("hash_start", 32'(hash_start), 32'(m_mode == M_START));
    check("busy", 32'(busy), 32'(m_mode == M_START || m_mode == M_WAIT));
    check("valid", 32'(valid), 32'(m_valid));
    check("err", 32'(err), 32'(m_err));
    check("word_sel", 32'(word_sel), 32'(m_sel));
    check("word", 32'(word), 32'(m_words[m_sel]));
  endtask

  task automatic model_step(input bit g, input bit s, input bit t, input bit d,
                            input logic [255:0] dig);
    bit ge;
    bit se;
    ge = g && !m_go_prev;
    se = s && !m_step_prev;
    m_go_prev = g;
    m_step_prev = s;
    case (m_mode)
      M_IDLE: if (ge) begin m_mode = M_START; m_valid = 0; m_err = 0; end
      M_START: begin m_mode = M_WAIT; m_wait_n = 0; end
      M_WAIT: begin
        if (d) begin
          for (int i = 0; i < 16; i++) m_words[i] = 16'((dig >> (16 * i)) & 256'hffff);
          m_valid = 1; m_sel = 0; m_dwell = 0; m_mode = M_SHOW;
        end else if (m_wait_n == TIMEOUT - 1) begin
          m_mode = M_IDLE; m_err = 1; m_valid = 0;
        end else begin
          m_wait_n++;
        end
      end
      default: begin
        if (se) begin
          m_sel = (m_sel + 1) % 16;
          m_dwell = 0;
        end
`ifdef AUTO_SCAN_EN
        else if (t) begin
          m_dwell++;
          if (m_dwell == DWELL) begin
            m_sel = (m_sel + 1) % 16;
            m_dwell = 0;
          end
        end
`else
        else if (t) m_dwell = 0;
`endif
        if (ge) begin m_mode = M_START; m_valid = 0; m_err = 0; m_dwell = 0; end
      end
    endcase
  endtask

  // one clock: drive at negedge, advance model, sample 1 ns after the rising edge
  task automatic cyc(input bit g, input bit s, input bit t, input bit d,
                     input logic [255:0] dig);
    @(negedge clk);
    go = g; step = s; tick = t; hash_done = d; hash_digest = dig;
    model_step(g, s, t, d, dig);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    go = 0; step = 0; tick = 0; hash_done = 0;
    model_reset();
    #1;
    check_all();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_all();
  endtask

  logic [255:0] rnd;
  bit           g_r;
  bit           s_r;

  initial begin
    rst = 1'b0; go = 0; step = 0; tick = 0; hash_done = 0; hash_digest = '0;
    model_reset();

    // reset
    do_reset();
    cyc(0, 0, 0, 0, '0);

    // normal run, done 10 cycles after the go edge
    cyc(1, 0, 0, 0, '0);
    check("start_pulse", 32'(hash_start), 32'd1);
    for (int i = 1; i < 10; i++) cyc(1, 0, 0, 0, '0);
    cyc(1, 0, 0, 1, REF_DIGEST);
    check("capture_word", 32'(word), 32'h6271);
    check("capture_valid", 32'(valid), 32'd1);

    // step through all 16 words and wrap
    for (int i = 0; i < 16; i++) begin
      cyc(1, 1, 0, 0, '0);
      if (i == 0) check("step_first", 32'(word), 32'h75a4);
      if (i == 14) check("step_last", 32'(word), 32'hd0e8);
      cyc(1, 0, 0, 0, '0);
    end
    check("step_wrap", 32'(word), 32'h6271);

    // timeout, then next go edge clears err
    cyc(0, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, '0);
    for (int i = 0; i < TIMEOUT + 3; i++) cyc(1, 0, 0, 0, '0);
    check("timeout_err", 32'(err), 32'd1);
    cyc(0, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, '0);
    check("err_cleared", 32'(err), 32'd0);

    // reset during WAIT; late hash_done is ignored
    cyc(1, 0, 0, 0, '0);
    do_reset();
    cyc(0, 0, 0, 1, REF_DIGEST);
    cyc(0, 0, 0, 0, '0);
    check("late_done_valid", 32'(valid), 32'd0);

`ifdef AUTO_SCAN_EN
    // auto-scan: every DWELL ticks, plus a step coincident with expiry
    cyc(1, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, '0);
    cyc(1, 0, 0, 1, REF_DIGEST);
    cyc(1, 0, 1, 0, '0);
    cyc(1, 0, 1, 0, '0);
    check("auto_adv", 32'(word_sel), 32'd1);
    cyc(1, 0, 1, 0, '0);
    cyc(1, 1, 1, 0, '0);
    check("auto_step_coincide", 32'(word_sel), 32'd2);
`endif

    // randomized traffic
    g_r = 0; s_r = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        g_r = 0; s_r = 0;
      end
      for (int k = 0; k < 8; k++) rnd[k*32 +: 32] = $urandom;
      if ($urandom_range(0, 11) == 0) g_r = !g_r;
      if ($urandom_range(0, 2) == 0) s_r = !s_r;
      cyc(g_r, s_r, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, rnd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
